// File: rtl/q24_div_ctrl.sv
// Bit-serial restoring-division sequencer: Q = floor(num * 2^FRAC / den), one quotient bit per clock, MSB first.
// Optional macro Q24_DIV0_SAT_EN: divide-by-zero saturates the accumulator to all ones at normal latency.
module q24_div_ctrl #(
  parameter int WIDTH = 25,
  parameter int NUM_W = 16,
  parameter int DEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic             busy,
  output logic             done,
  output logic             err_div0,
  output logic [DEN_W-1:0] rem,
  output logic             acc_load,
  output logic [1:0]       acc_mux
);

  localparam int FRAC  = WIDTH - NUM_W;
  localparam int CNT_W = $clog2(WIDTH);

  // Handshake: start is honoured only in S_IDLE; busy spans CLEAR..DONE and done pulses for one cycle.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_ITER  = 3'd2,
    S_DONE  = 3'd3,
    S_SAT   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [DEN_W-1:0]   r_q, r_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [DEN_W-1:0]   den_q, den_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;

  logic [DEN_W:0]     trial;
  logic               trial_ge;
  logic [DEN_W-1:0]   trial_diff;
  logic               cnt_last;

  // R < den holds after every step, so the difference always fits in DEN_W bits.
  assign trial      = {r_q, dvd_q[WIDTH-1]};
  assign trial_ge   = (trial >= {1'b0, den_q});
  assign trial_diff = trial[DEN_W-1:0] - den_q;
  assign cnt_last   = (cnt_q == CNT_W'(WIDTH - 1));

  assign err_div0 = err_q;
  assign rem      = r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      dvd_q   <= '0;
      den_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      dvd_q   <= dvd_d;
      den_q   <= den_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    dvd_d    = dvd_q;
    den_d    = den_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    busy     = 1'b0;
    done     = 1'b0;
    acc_load = 1'b0;
    acc_mux  = 2'b00;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          dvd_d   = WIDTH'(num) << FRAC;
          den_d   = den;
          r_d     = '0;
          cnt_d   = '0;
          err_d   = (den == '0);
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        busy     = 1'b1;
        acc_load = 1'b1;
`ifdef Q24_DIV0_SAT_EN
        state_d  = (den_q != '0) ? S_ITER : S_SAT;
`else
        state_d  = (den_q != '0) ? S_ITER : S_DONE;
`endif
      end
      S_ITER: begin
        busy = 1'b1;
        if (trial_ge) begin
          r_d     = trial_diff;
          acc_mux = 2'b10;
        end else begin
          r_d     = trial[DEN_W-1:0];
          acc_mux = 2'b01;
        end
        dvd_d = dvd_q << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_last) state_d = S_DONE;
      end
`ifdef Q24_DIV0_SAT_EN
      S_SAT: begin
        busy    = 1'b1;
        acc_mux = 2'b10;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_last) state_d = S_DONE;
      end
`endif
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_q24_div_ctrl.sv
// Directed bench for q24_div_ctrl with a behavioural model of the external shift-accumulate register.
module tb_q24_div_ctrl;
  localparam int WIDTH = 25;
  localparam int NUM_W = 16;
  localparam int DEN_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [NUM_W-1:0] num;
  logic [DEN_W-1:0] den;
  logic             busy;
  logic             done;
  logic             err_div0;
  logic [DEN_W-1:0] rem;
  logic             acc_load;
  logic [1:0]       acc_mux;

  q24_div_ctrl #(.WIDTH(WIDTH), .NUM_W(NUM_W), .DEN_W(DEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .num(num), .den(den),
    .busy(busy), .done(done), .err_div0(err_div0), .rem(rem),
    .acc_load(acc_load), .acc_mux(acc_mux)
  );

  always #5 clk = ~clk;

  // External accumulator driven by the DUT's commands.
  logic [WIDTH-1:0] acc_m;
  logic             log_en = 1'b0;
  logic [1:0]       mux_obs_q[$];

  always @(posedge clk) begin
    if (acc_load) acc_m <= '0;
    else if (acc_mux == 2'b01) acc_m <= {acc_m[WIDTH-2:0], 1'b0};
    else if (acc_mux == 2'b10) acc_m <= {acc_m[WIDTH-2:0], 1'b1};
    if (log_en && acc_mux != 2'b00) mux_obs_q.push_back(acc_mux);
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic run_op(input string tag, input logic [15:0] n, input logic [15:0] d,
                        input logic [24:0] q_exp, input logic [15:0] r_exp, input logic e_exp,
                        input int lat_exp, input bit glitch);
    int lat;
    @(negedge clk);
    num = n; den = d; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    num = 16'($urandom); den = 16'($urandom);
    lat = 1;
    while (!done && lat < 40) begin
      start = (glitch && lat == 5);
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    check({tag, " latency"}, lat, lat_exp);
    check({tag, " done"}, done, 1);
    check({tag, " busy_done"}, busy, 1);
    check({tag, " mux_done"}, acc_mux, 0);
    check({tag, " quotient"}, acc_m, q_exp);
    check({tag, " rem"}, rem, r_exp);
    check({tag, " err"}, err_div0, e_exp);
    if (glitch) begin
      start = 1'b1; num = 16'h1234; den = 16'h0000;
    end
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, " busy_idle"}, busy, 0);
    check({tag, " done_idle"}, done, 0);
    check({tag, " q_hold"}, acc_m, q_exp);
    check({tag, " rem_hold"}, rem, r_exp);
    check({tag, " err_hold"}, err_div0, e_exp);
  endtask

  initial begin
    logic [24:0] q_bits;
    logic [1:0]  mux_exp;
    logic [24:0] q_div0;
    int          lat_div0;
`ifdef Q24_DIV0_SAT_EN
    q_div0 = 25'h1FFFFFF; lat_div0 = 27;
`else
    q_div0 = 25'h0;       lat_div0 = 2;
`endif
    rst = 1'b1; start = 1'b0; num = '0; den = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst err", err_div0, 0);
    check("rst rem", rem, 0);
    check("rst load", acc_load, 0);
    check("rst mux", acc_mux, 0);
    @(negedge clk);
    rst = 1'b0;

    mux_obs_q.delete();
    log_en = 1'b1;
    run_op("3/2", 16'd3, 16'd2, 25'h000300, 16'd0, 1'b0, 27, 1'b0);
    log_en = 1'b0;
    check("3/2 mux count", mux_obs_q.size(), 25);
    q_bits = 25'h000300;
    for (int i = 0; i < WIDTH; i++) begin
      mux_exp = q_bits[WIDTH-1-i] ? 2'b10 : 2'b01;
      check($sformatf("3/2 mux[%0d]", i), (i < mux_obs_q.size()) ? mux_obs_q[i] : 2'b00, mux_exp);
    end

    run_op("1/3", 16'd1, 16'd3, 25'h0000AA, 16'd2, 1'b0, 27, 1'b0);
    run_op("ffff/1", 16'hFFFF, 16'd1, 25'h1FFFE00, 16'd0, 1'b0, 27, 1'b0);
    run_op("ffff/ffff", 16'hFFFF, 16'hFFFF, 25'h0000200, 16'd0, 1'b0, 27, 1'b0);
    run_op("glitch 1/3", 16'd1, 16'd3, 25'h0000AA, 16'd2, 1'b0, 27, 1'b1);
    run_op("b2b 5/0", 16'd5, 16'd0, q_div0, 16'd0, 1'b1, lat_div0, 1'b0);

    @(negedge clk);
    num = 16'hFFFF; den = 16'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    check("pre-rst busy", busy, 1);
    rst = 1'b1;
    #1;
    check("async busy", busy, 0);
    check("async done", done, 0);
    check("async err", err_div0, 0);
    check("async rem", rem, 0);
    check("async load", acc_load, 0);
    check("async mux", acc_mux, 0);
    @(negedge clk);
    rst = 1'b0;
    run_op("7/7", 16'd7, 16'd7, 25'h0000200, 16'd0, 1'b0, 27, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
